ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage feeding the core's inst input. Accepts the next PC from the
//  PC register via valid/ready, issues one read to instruction memory, waits a variable
//  latency, and holds the fetched word stable with inst_valid until the core retires it.
//  Flags misaligned PC, bus error and response timeout. At most one outstanding request.
// PARAMETERS
//  ADDR_W    32            address width
//  DATA_W    32            instruction width
//  TIMEOUT   255           max WAIT cycles before timeout error (1..2^CNT_W-1)
//  CNT_W     8             timeout counter width
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  pc             in   ADDR_W  PC to fetch
//  pc_valid       in   1       pc valid
//  pc_ready       out  1       ifu can accept a PC
//  imem_req_valid out  1       memory read request valid
//  imem_req_ready in   1       memory accepts request
//  imem_req_addr  out  ADDR_W  request address (registered pc)
//  imem_rsp_valid in   1       read data valid (1-cycle pulse)
//  imem_rsp_data  in   DATA_W  read data
//  imem_rsp_err   in   1       bus error with response
//  inst           out  DATA_W  fetched instruction
//  inst_pc        out  ADDR_W  PC of inst
//  inst_valid     out  1       inst/inst_pc/fetch_err valid
//  inst_ready     in   1       core consumes inst this cycle
//  fetch_err      out  2       0 none, 1 misaligned, 2 bus error, 3 timeout
// BEHAVIOUR
//  Reset (sync): state=IDLE, pc_ready=1, imem_req_valid=0, imem_req_addr=0, inst=0,
//   inst_pc=0, inst_valid=0, fetch_err=0, timeout count=0, drop_pending=0.
//  FSM states IDLE, REQ, WAIT, HOLD; all outputs driven from registers / state decode.
//  IDLE: pc_ready=1. pc_valid&pc_ready: latch pc into imem_req_addr/inst_pc.
//   pc[1:0]!=0 -> HOLD, fetch_err=1, inst=0, no memory request. Else -> REQ.
//  REQ: imem_req_valid=1, addr stable until imem_req_ready; handshake -> WAIT, count=0.
//   imem_req_valid never drops without handshake.
//  WAIT: count++ each cycle. imem_rsp_valid: if drop_pending, clear it, discard data,
//   stay WAIT (count unaffected). Else inst<=rsp_data, fetch_err<=rsp_err?2:0 (inst=0
//   on err), -> HOLD. count==TIMEOUT with no rsp -> HOLD, fetch_err=3, inst=0,
//   drop_pending<=1. rsp in same cycle as count==TIMEOUT: response wins, no timeout.
//  HOLD: inst_valid=1; inst, inst_pc, fetch_err stable. inst_ready -> IDLE next cycle,
//   inst_valid=0. pc_ready=0 in REQ/WAIT/HOLD (no PC accept in HOLD's retire cycle).
//  imem_rsp_valid outside WAIT: ignored; if drop_pending, clears it.
//  Latency: pc handshake cycle N, req_ready at N+1, rsp at N+k (k>=2) -> inst_valid
//   at N+k+1. Minimum 3 cycles. Misaligned: inst_valid at N+1.
//  Reset mid-operation: returns to reset values the next edge regardless of state;
//   drop_pending cleared (memory is reset by the same rst).
//  Counter saturates at TIMEOUT; never wraps.
// STRUCTURE
//  fetch_pkg: state enum (IDLE/REQ/WAIT/HOLD), FETCH_ERR_* codes, RESET_PC constant
//   (shared with the PC register).
//  Sub-module ifu_timeout_ctr: clear/enable/saturating counter with expired flag at
//   TIMEOUT. FSM and datapath registers stay in ifu_fetch.
// TESTING
//  1 Reset, pc=0x8000_0000 valid, req_ready=1, rsp 1 cycle later data=0x0000_0413 ->
//    inst_valid 3 cycles after pc handshake, inst=0x0000_0413, inst_pc=0x8000_0000, err=0.
//  2 req_ready low 4 cycles -> req_valid and addr held stable, single request issued.
//  3 inst_ready held low 5 cycles in HOLD -> inst/inst_pc stable, pc_ready=0 throughout.
//  4 pc=0x8000_0002 -> no imem request, inst_valid next cycle, fetch_err=1, inst=0.
//  5 TIMEOUT=4, no rsp -> fetch_err=3 after 4 WAIT cycles; late rsp 0xDEAD_BEEF then
//    next fetch rsp 0x0000_0013 -> second inst=0x0000_0013, stale word never seen.
//  6 rst asserted in WAIT -> next cycle all outputs at reset values, pc_ready=1; rsp_err=1
//    on a normal fetch -> fetch_err=2, inst=0.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: fetch FSM states, fetch error codes and the shared reset PC.
package ifu_fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    typedef enum logic [1:0] {
        FETCH_ERR_NONE,
        FETCH_ERR_MISALIGNED,
        FETCH_ERR_BUS,
        FETCH_ERR_TIMEOUT
    } fetch_err_t;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: PC intake, instruction memory and core-side instruction handshakes.
interface ifu_fetch_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              imem_rsp_err;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [1:0]        fetch_err;
    modport master (
        input  pc, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready,
        output pc_ready, imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid, fetch_err
    );
    modport slave (
        output pc, pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready,
        input  pc_ready, imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid, fetch_err
    );
endinterface

// File: rtl/ifu_fetch_timeout_ctr.sv
// ifu_fetch_timeout_ctr: saturating response-wait counter, expired once it reaches TIMEOUT.
module ifu_fetch_timeout_ctr #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (en && count != LIMIT) count <= count + 1'b1;
    assign expired = count == LIMIT;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with misalign, bus error and timeout flags.
module ifu_fetch import ifu_fetch_pkg::*; #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic        clk,
    input logic        rst,
    ifu_fetch_if.master bus
);
    state_t            state, state_d;
    fetch_err_t        err_q;
    logic [ADDR_W-1:0] addr_q, pc_q;
    logic [DATA_W-1:0] inst_q;
    logic              drop_pending, expired;
    logic              pc_hs, misaligned, req_hs, rsp_take, timed_out;
    assign pc_hs      = state == IDLE && bus.pc_valid;
    assign misaligned = bus.pc[1:0] != 2'b00;
    assign req_hs     = state == REQ && bus.imem_req_ready;
    assign rsp_take   = state == WAIT && bus.imem_rsp_valid && !drop_pending;
    // A response arriving on the expiry cycle wins over the timeout
    assign timed_out  = state == WAIT && expired && !bus.imem_rsp_valid;
    ifu_fetch_timeout_ctr #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (req_hs),
        .en      (state == WAIT),
        .expired (expired)
    );
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = pc_hs ? (misaligned ? HOLD : REQ) : IDLE;
            REQ:     state_d = bus.imem_req_ready ? WAIT : REQ;
            WAIT:    state_d = (rsp_take || timed_out) ? HOLD : WAIT;
            default: state_d = bus.inst_ready ? IDLE : HOLD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            pc_q         <= '0;
            inst_q       <= '0;
            err_q        <= FETCH_ERR_NONE;
            drop_pending <= 1'b0;
        end else begin
            if (pc_hs) begin
                addr_q <= bus.pc;
                pc_q   <= bus.pc;
                err_q  <= misaligned ? FETCH_ERR_MISALIGNED : FETCH_ERR_NONE;
                if (misaligned) inst_q <= '0;
            end
            if (rsp_take) begin
                inst_q <= bus.imem_rsp_err ? '0 : bus.imem_rsp_data;
                err_q  <= bus.imem_rsp_err ? FETCH_ERR_BUS : FETCH_ERR_NONE;
            end
            // The abandoned request still owes a response; swallow it when it lands
            if (timed_out) begin
                inst_q       <= '0;
                err_q        <= FETCH_ERR_TIMEOUT;
                drop_pending <= 1'b1;
            end else if (bus.imem_rsp_valid && drop_pending) begin
                drop_pending <= 1'b0;
            end
        end
    end
    assign bus.pc_ready       = state == IDLE;
    assign bus.imem_req_valid = state == REQ;
    assign bus.imem_req_addr  = addr_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = pc_q;
    assign bus.inst_valid     = state == HOLD;
    assign bus.fetch_err      = err_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: table-driven fetch vectors plus timeout, stale-drop and reset sequences.
module tb_ifu_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    ifu_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ifu_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    int tests = 0;
    int fails = 0;
    int req_cnt = 0;
    always @(posedge clk) if (bus.imem_req_valid && bus.imem_req_ready) req_cnt <= req_cnt + 1;
    typedef struct {
        logic [31:0] pc;
        int          req_wait;
        int          rsp_lat;
        logic [31:0] data;
        logic        err;
        int          hold;
        logic [31:0] exp_inst;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs[7];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, " pc_ready"}, 64'(bus.pc_ready), 64'd1);
        check({tag, " req_valid"}, 64'(bus.imem_req_valid), 64'd0);
        check({tag, " req_addr"}, 64'(bus.imem_req_addr), 64'd0);
        check({tag, " inst"}, 64'(bus.inst), 64'd0);
        check({tag, " inst_pc"}, 64'(bus.inst_pc), 64'd0);
        check({tag, " inst_valid"}, 64'(bus.inst_valid), 64'd0);
        check({tag, " fetch_err"}, 64'(bus.fetch_err), 64'd0);
    endtask
    task automatic retire(input string tag);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        check({tag, " retired_valid"}, 64'(bus.inst_valid), 64'd0);
        check({tag, " retired_pc_ready"}, 64'(bus.pc_ready), 64'd1);
    endtask
    task automatic wait_inst_valid(inout int lat);
        for (int i = 0; i < 20 && !bus.inst_valid; i++) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic fetch(input vec_t v, input string tag);
        int lat;
        int n0;
        logic [31:0] si, sp;
        n0 = req_cnt;
        bus.pc = v.pc;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        lat = 1;
        if (v.pc[1:0] == 2'b00) begin
            for (int i = 0; i < v.req_wait; i++) begin
                check({tag, " req_held"}, {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {31'd0, 1'b1, v.pc});
                @(negedge clk);
                lat++;
            end
            bus.imem_req_ready = 1'b1;
            @(negedge clk);
            bus.imem_req_ready = 1'b0;
            lat++;
            repeat (v.rsp_lat - 1) begin
                @(negedge clk);
                lat++;
            end
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = v.data;
            bus.imem_rsp_err = v.err;
            @(negedge clk);
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err = 1'b0;
            lat++;
        end else begin
            check({tag, " no_req"}, 64'(bus.imem_req_valid), 64'd0);
        end
        wait_inst_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " req_count"}, 64'(req_cnt - n0), (v.pc[1:0] == 2'b00) ? 64'd1 : 64'd0);
        si = bus.inst;
        sp = bus.inst_pc;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check({tag, " hold_stable"}, {bus.inst, bus.inst_pc}, {si, sp});
            check({tag, " hold_flags"}, {62'd0, bus.inst_valid, bus.pc_ready}, {62'd0, 1'b1, 1'b0});
        end
        check({tag, " inst"}, 64'(bus.inst), 64'(v.exp_inst));
        check({tag, " inst_pc"}, 64'(bus.inst_pc), 64'(v.pc));
        check({tag, " fetch_err"}, 64'(bus.fetch_err), 64'(v.exp_err));
        retire(tag);
    endtask
    task automatic start_to_wait(input logic [31:0] p);
        bus.pc = p;
        bus.pc_valid = 1'b1;
        @(negedge clk);
        bus.pc_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
    endtask
    task automatic timeout_fetch(input logic [31:0] p, input string tag);
        int lat;
        start_to_wait(p);
        lat = 2;
        for (int i = 0; i < 4; i++) begin
            check({tag, " no_early_valid"}, 64'(bus.inst_valid), 64'd0);
            @(negedge clk);
            lat++;
        end
        wait_inst_valid(lat);
        check({tag, " valid"}, 64'(bus.inst_valid), 64'd1);
        check({tag, " err"}, 64'(bus.fetch_err), 64'd3);
        check({tag, " inst"}, 64'(bus.inst), 64'd0);
        check({tag, " inst_pc"}, 64'(bus.inst_pc), 64'(p));
        retire(tag);
    endtask
    initial begin
        vecs[0] = '{32'h8000_0000, 0, 1, 32'h0000_0413, 1'b0, 0, 32'h0000_0413, 2'd0, 3};
        vecs[1] = '{32'h8000_0004, 4, 1, 32'h00A0_0093, 1'b0, 0, 32'h00A0_0093, 2'd0, 7};
        vecs[2] = '{32'h8000_0008, 0, 1, 32'h1234_5678, 1'b0, 5, 32'h1234_5678, 2'd0, 3};
        vecs[3] = '{32'h8000_0002, 0, 1, 32'h0,         1'b0, 0, 32'h0,         2'd1, 1};
        vecs[4] = '{32'h8000_000C, 0, 3, 32'hFFFF_FFFF, 1'b1, 0, 32'h0,         2'd2, 5};
        vecs[5] = '{32'h0000_0001, 0, 1, 32'h0,         1'b0, 2, 32'h0,         2'd1, 1};
        vecs[6] = '{32'hFFFF_FFFC, 2, 2, 32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 2'd0, 6};
        rst = 1'b1;
        bus.pc = '0;
        bus.pc_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.imem_rsp_err = 1'b0;
        bus.inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) fetch(vecs[i], $sformatf("vec%0d", i));
        timeout_fetch(32'h8000_0010, "tmo1");
        start_to_wait(32'h8000_0014);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("stale_dropped", 64'(bus.inst_valid), 64'd0);
        bus.imem_rsp_data = 32'h0000_0013;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        check("after_drop valid", 64'(bus.inst_valid), 64'd1);
        check("after_drop inst", 64'(bus.inst), 64'h13);
        check("after_drop err", 64'(bus.fetch_err), 64'd0);
        retire("after_drop");
        timeout_fetch(32'h8000_0018, "tmo2");
        start_to_wait(32'h8000_001C);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        fetch('{32'h8000_0020, 0, 1, 32'h0000_0093, 1'b0, 0, 32'h0000_0093, 2'd0, 3}, "post_reset");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
